uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Sequencer sitting directly behind the 16x-oversampled UART receiver; consumes its byte stream
//  (rx_data/rx_valid/rx_error) and assembles framed commands: SYNC, ADDR, LEN, PAYLOAD[LEN], CSUM.
//  Validated payload is buffered and released downstream on a valid/ready stream tagged with ADDR.
//  Corrupt, oversize, truncated or stalled frames are discarded and reported with an error code.
// PARAMETERS
//  CLK_FREQ      50_000_000  system clock, Hz
//  BAUD          115200      line rate; TIMEOUT_CYC = TIMEOUT_BITS*(CLK_FREQ/BAUD)
//  MAX_LEN       16          payload buffer depth, bytes (1..255)
//  SYNC_BYTE     8'hA5       frame start marker
//  TIMEOUT_BITS  20          inter-byte timeout in bit times (default -> 8680 cycles)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  synchronous active-low reset
//  rx_data    in   8  received byte from UART receiver
//  rx_valid   in   1  1-cycle pulse, rx_data valid
//  rx_error   in   1  1-cycle pulse, stop-bit framing error
//  out_addr   out  8  ADDR field of the frame being drained
//  out_data   out  8  payload byte
//  out_last   out  1  final payload byte of frame
//  out_valid  out  1  payload byte available
//  out_ready  in   1  downstream accepts byte when out_valid&out_ready
//  frame_ok   out  1  1-cycle pulse: frame accepted
//  frame_err  out  1  1-cycle pulse: frame/byte rejected
//  err_code   out  3  0 FRAMING,1 BADLEN,2 CSUM,3 TIMEOUT,4 OVERRUN; held until next frame_err
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  - One clock; reset synchronous active-low: all outputs 0, state IDLE, counters/checksum 0.
//  - States: IDLE -> ADDR -> LEN -> PAYLOAD -> CSUM -> DRAIN -> IDLE; transitions on rx_valid.
//  - IDLE: rx_valid with rx_data==SYNC_BYTE -> ADDR; other bytes and rx_error ignored.
//  - ADDR: latch addr, sum<=rx_data. LEN: LEN>MAX_LEN -> BADLEN, IDLE; LEN==0 -> CSUM; else PAYLOAD.
//  - PAYLOAD: write buf[idx], idx++, sum+=byte; after LEN bytes -> CSUM.
//  - CSUM: (sum+rx_data)&8'hFF==0 -> frame_ok next cycle; LEN>0 -> DRAIN, LEN==0 -> IDLE.
//    Mismatch -> CSUM error, IDLE. All sums are 8-bit modulo 256.
//  - DRAIN: out_valid=1 from the cycle frame_ok pulses; out_data=buf[rd_idx]; rd_idx++ on
//    handshake; out_last when rd_idx==LEN-1; after last handshake out_valid=0 next cycle, IDLE.
//    out_data/out_addr/out_last stable while out_valid&!out_ready.
//  - rx_valid during DRAIN: byte dropped, OVERRUN error; drain continues unaffected.
//  - rx_error in ADDR..CSUM -> FRAMING error, IDLE; in DRAIN -> ignored.
//  - Timeout counter runs in ADDR..CSUM, cleared on every rx_valid; reaching TIMEOUT_CYC-1 ->
//    TIMEOUT error, IDLE. Not active in IDLE/DRAIN.
//  - Simultaneous: rx_valid with timeout terminal count -> byte accepted, counter cleared;
//    rx_valid with rx_error -> rx_error wins (FRAMING).
//  - frame_err and err_code update in the same cycle; err_code changes only on frame_err.
//  - Aborted frames leave buffer contents stale; never exposed (out_valid only in DRAIN).
//  - Reset mid-frame or mid-drain: immediate IDLE, out_valid 0, partial frame discarded.
// CONFIGURATION
//  UART_FRM_STATS_EN defined: adds outputs ok_cnt[15:0], err_cnt[15:0]; increment on frame_ok /
//   frame_err, saturate at 16'hFFFF, cleared by reset.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 A5,10,02,11,22,BB -> frame_ok; drain 11 then 22 (out_last on 22), out_addr=10; busy low after.
//  2 A5,10,02,11,22,BC -> frame_err, err_code=2, no out_valid; next good frame accepted.
//  3 A5,07,11 (MAX_LEN=16) -> frame_err, err_code=1 after LEN; trailing bytes ignored until A5.
//  4 A5,10 then idle 8680 cycles -> frame_err, err_code=3, IDLE; byte at cycle 8679 instead resets timer.
//  5 good frame, out_ready=0 for 50 cycles, byte sent in DRAIN -> err_code=4, data held, drain intact.
//  6 rx_error after LEN; reset asserted mid-DRAIN -> FRAMING error; all outputs 0 next cycle.

Source files
------------

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-stream and payload-stream signals of the UART frame controller.
// slave: the frame controller; master: UART receiver, downstream sink and monitor side.
interface uart_rx_frame_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic [7:0] out_addr;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;
    logic       busy;

    modport slave (
        input  rx_data, rx_valid, rx_error, out_ready,
        output out_addr, out_data, out_last, out_valid,
        output frame_ok, frame_err, err_code, busy
    );

    modport master (
        output rx_data, rx_valid, rx_error, out_ready,
        input  out_addr, out_data, out_last, out_valid,
        input  frame_ok, frame_err, err_code, busy
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Assembles SYNC/ADDR/LEN/PAYLOAD/CSUM frames from a UART byte stream and drains the payload.
// Define UART_FRM_STATS_EN to add saturating ok_cnt/err_cnt frame counters.
module uart_rx_frame_ctrl #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic clk,
    input  logic rst_n,
    uart_rx_frame_ctrl_if.slave bus
`ifdef UART_FRM_STATS_EN
    ,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt
`endif
);
    localparam int unsigned TIMEOUT_CYC = TIMEOUT_BITS * (CLK_FREQ / BAUD);
    localparam int unsigned TMO_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned BUF_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN
    } state_e;

    typedef enum logic [2:0] {
        ERR_FRAMING = 3'd0,
        ERR_BADLEN  = 3'd1,
        ERR_CSUM    = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_OVERRUN = 3'd4
    } err_e;

    state_e           state;
    logic [7:0]       addr;
    logic [7:0]       len;
    logic [7:0]       idx;
    logic [7:0]       rd_idx;
    logic [7:0]       rd_nxt;
    logic [7:0]       sum;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       buf_mem [MAX_LEN];

    assign rd_nxt = rd_idx + 8'd1;

    // NOTE: the payload buffer deliberately has no reset; its bytes are only read in DRAIN,
    // after the current frame has overwritten every entry it will expose.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && bus.rx_valid && !bus.rx_error)
            buf_mem[idx[BUF_W-1:0]] <= bus.rx_data;
    end

    task automatic abort_frame(input err_e code);
        state         <= S_IDLE;
        bus.busy      <= 1'b0;
        bus.frame_err <= 1'b1;
        bus.err_code  <= code;
    endtask

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            addr          <= '0;
            len           <= '0;
            idx           <= '0;
            rd_idx        <= '0;
            sum           <= '0;
            tmo_cnt       <= '0;
            bus.out_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.frame_ok  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.err_code  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.frame_ok  <= 1'b0;
            bus.frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                        state    <= S_ADDR;
                        bus.busy <= 1'b1;
                        tmo_cnt  <= '0;
                    end
                end
                S_ADDR, S_LEN, S_PAYLOAD, S_CSUM: begin
                    // rx_error outranks a coincident byte; a byte outranks the timeout terminal count
                    if (bus.rx_error) begin
                        abort_frame(ERR_FRAMING);
                    end else if (bus.rx_valid) begin
                        tmo_cnt <= '0;
                        case (state)
                            S_ADDR: begin
                                addr  <= bus.rx_data;
                                sum   <= bus.rx_data;
                                state <= S_LEN;
                            end
                            S_LEN: begin
                                if (bus.rx_data > MAX_LEN_B) begin
                                    abort_frame(ERR_BADLEN);
                                end else begin
                                    len   <= bus.rx_data;
                                    sum   <= sum + bus.rx_data;
                                    idx   <= '0;
                                    state <= (bus.rx_data == 8'd0) ? S_CSUM : S_PAYLOAD;
                                end
                            end
                            S_PAYLOAD: begin
                                sum <= sum + bus.rx_data;
                                idx <= idx + 8'd1;
                                if (idx == len - 8'd1)
                                    state <= S_CSUM;
                            end
                            default: begin
                                if ((sum + bus.rx_data) == 8'h00) begin
                                    bus.frame_ok <= 1'b1;
                                    if (len != 8'd0) begin
                                        state         <= S_DRAIN;
                                        rd_idx        <= '0;
                                        bus.out_valid <= 1'b1;
                                        bus.out_addr  <= addr;
                                        bus.out_data  <= buf_mem[0];
                                        bus.out_last  <= (len == 8'd1);
                                    end else begin
                                        state    <= S_IDLE;
                                        bus.busy <= 1'b0;
                                    end
                                end else begin
                                    abort_frame(ERR_CSUM);
                                end
                            end
                        endcase
                    end else if (tmo_cnt == TMO_LAST) begin
                        abort_frame(ERR_TIMEOUT);
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (bus.rx_valid) begin
                        bus.frame_err <= 1'b1;
                        bus.err_code  <= ERR_OVERRUN;
                    end
                    if (bus.out_ready) begin
                        if (bus.out_last) begin
                            state         <= S_IDLE;
                            bus.busy      <= 1'b0;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                        end else begin
                            rd_idx       <= rd_nxt;
                            bus.out_data <= buf_mem[rd_nxt[BUF_W-1:0]];
                            bus.out_last <= (rd_nxt == len - 8'd1);
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_FRM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ok_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (bus.frame_ok && ok_cnt != 16'hFFFF)
                ok_cnt <= ok_cnt + 16'd1;
            if (bus.frame_err && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: good/bad frames, timeout, overrun, framing and reset,
// with a payload scoreboard checked on every downstream handshake.
module tb_uart_rx_frame_ctrl;
    typedef logic [7:0] byte_q_t [$];
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   ok_seen;
    int   err_seen;
    int   err_snap;
    beat_t   exp_q [$];
    byte_q_t pl;

    uart_rx_frame_ctrl_if bus ();

`ifdef UART_FRM_STATS_EN
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;
`endif

    uart_rx_frame_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef UART_FRM_STATS_EN
        ,
        .ok_cnt  (ok_cnt),
        .err_cnt (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    // Sends a whole frame; delta corrupts the checksum, good queues the expected drain beats
    task automatic send_frame(input logic [7:0] a, input byte_q_t p, input logic [7:0] delta,
                              input bit good);
        logic [7:0] s;
        s = a + 8'(p.size());
        foreach (p[i]) s = s + p[i];
        if (good)
            foreach (p[i]) exp_q.push_back('{a, p[i], (i == p.size() - 1)});
        send(8'hA5);
        send(a);
        send(8'(p.size()));
        foreach (p[i]) send(p[i]);
        send((8'h00 - s) + delta);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ok_seen  = 0;
            err_seen = 0;
        end else begin
            if (bus.frame_ok)  ok_seen++;
            if (bus.frame_err) err_seen++;
            if (bus.out_valid && bus.out_ready) begin
                check("drain_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0)
                    check("drain_beat", 32'({bus.out_addr, bus.out_data, bus.out_last}),
                          32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_frame_ok", 32'(bus.frame_ok), 0);
        check("rst_frame_err", 32'(bus.frame_err), 0);
        check("rst_err_code", 32'(bus.err_code), 0);
        rst_n = 1'b1;
        tick();

        // Good two-byte frame drained with ready held high
        bus.out_ready = 1'b1;
        pl = {8'h11, 8'h22};
        send_frame(8'h10, pl, 8'h00, 1'b1);
        check("t1_frame_ok", 32'(bus.frame_ok), 1);
        check("t1_out_valid", 32'(bus.out_valid), 1);
        check("t1_first_data", 32'(bus.out_data), 32'h11);
        repeat (4) tick();
        check("t1_busy_after", 32'(bus.busy), 0);
        check("t1_out_valid_after", 32'(bus.out_valid), 0);
        check("t1_drained", 32'(exp_q.size()), 0);

        // Checksum off by one, then a good frame recovers
        send_frame(8'h10, pl, 8'h01, 1'b0);
        check("t2_frame_err", 32'(bus.frame_err), 1);
        check("t2_err_code", 32'(bus.err_code), 2);
        check("t2_out_valid", 32'(bus.out_valid), 0);
        check("t2_busy", 32'(bus.busy), 0);
        tick();
        check("t2_err_pulse", 32'(bus.frame_err), 0);
        pl = {8'h33};
        send_frame(8'h20, pl, 8'h00, 1'b1);
        check("t2_recover_ok", 32'(bus.frame_ok), 1);
        check("t2_recover_last", 32'(bus.out_last), 1);
        repeat (4) tick();
        check("t2_drained", 32'(exp_q.size()), 0);

        // Oversize LEN, trailing bytes ignored, then a zero-length frame
        send(8'hA5);
        send(8'h07);
        send(8'h11);
        check("t3_frame_err", 32'(bus.frame_err), 1);
        check("t3_err_code", 32'(bus.err_code), 1);
        check("t3_busy", 32'(bus.busy), 0);
        tick();
        err_snap = err_seen;
        send(8'h22);
        send(8'h33);
        send(8'h44);
        tick();
        check("t3_trailing_ignored", 32'(err_seen - err_snap), 0);
        check("t3_trailing_idle", 32'(bus.busy), 0);
        pl.delete();
        send_frame(8'h01, pl, 8'h00, 1'b1);
        check("t3_len0_ok", 32'(bus.frame_ok), 1);
        check("t3_len0_no_drain", 32'(bus.out_valid), 0);
        check("t3_len0_idle", 32'(bus.busy), 0);

        // Inter-byte timeout fires exactly TIMEOUT_CYC idle cycles after the last byte
        send(8'hA5);
        send(8'h10);
        repeat (8679) tick();
        check("t4_no_early_timeout", 32'(bus.frame_err), 0);
        check("t4_still_busy", 32'(bus.busy), 1);
        tick();
        check("t4_timeout_err", 32'(bus.frame_err), 1);
        check("t4_timeout_code", 32'(bus.err_code), 3);
        check("t4_timeout_idle", 32'(bus.busy), 0);

        // A byte coinciding with the terminal count is accepted and restarts the timer
        send(8'hA5);
        send(8'h10);
        repeat (8679) tick();
        send(8'h00);
        check("t4b_byte_accepted", 32'(bus.frame_err), 0);
        check("t4b_busy", 32'(bus.busy), 1);
        send(8'hF0);
        check("t4b_frame_ok", 32'(bus.frame_ok), 1);

        // Backpressured drain with a byte arriving during DRAIN
        bus.out_ready = 1'b0;
        pl = {8'h01, 8'h02, 8'h03};
        send_frame(8'h30, pl, 8'h00, 1'b1);
        check("t5_frame_ok", 32'(bus.frame_ok), 1);
        repeat (20) tick();
        send(8'h55);
        check("t5_overrun_err", 32'(bus.frame_err), 1);
        check("t5_overrun_code", 32'(bus.err_code), 4);
        check("t5_still_valid", 32'(bus.out_valid), 1);
        repeat (29) tick();
        check("t5_data_held", 32'({bus.out_addr, bus.out_data, bus.out_last}), 32'h3001_0 >> 0 == 0 ? 0 : {8'h30, 8'h01, 1'b0});
        check("t5_code_held", 32'(bus.err_code), 4);
        bus.out_ready = 1'b1;
        repeat (6) tick();
        check("t5_drained", 32'(exp_q.size()), 0);
        check("t5_idle", 32'(bus.busy), 0);

        // rx_error while collecting payload
        send(8'hA5);
        send(8'h40);
        send(8'h05);
        bus.rx_error = 1'b1;
        tick();
        bus.rx_error = 1'b0;
        check("t6_framing_err", 32'(bus.frame_err), 1);
        check("t6_framing_code", 32'(bus.err_code), 0);
        check("t6_framing_idle", 32'(bus.busy), 0);

        // rx_error wins over a coincident byte
        pl = {8'h44};
        send_frame(8'h41, pl, 8'h05, 1'b0);
        check("t6_csum_code", 32'(bus.err_code), 2);
        send(8'hA5);
        send(8'h41);
        bus.rx_data = 8'h01;
        bus.rx_valid = 1'b1;
        bus.rx_error = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        check("t6_simul_err", 32'(bus.frame_err), 1);
        check("t6_simul_code", 32'(bus.err_code), 0);
        check("t6_simul_idle", 32'(bus.busy), 0);

        // Reset asserted mid-drain
        bus.out_ready = 1'b0;
        pl = {8'hAA, 8'hBB};
        send_frame(8'h50, pl, 8'h00, 1'b1);
        check("t6_drain_valid", 32'(bus.out_valid), 1);
        send(8'h66);
        check("t6_overrun_code", 32'(bus.err_code), 4);
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        check("t6_rst_out_valid", 32'(bus.out_valid), 0);
        check("t6_rst_busy", 32'(bus.busy), 0);
        check("t6_rst_err_code", 32'(bus.err_code), 0);
        check("t6_rst_out_addr", 32'(bus.out_addr), 0);
        check("t6_rst_out_data", 32'(bus.out_data), 0);
        check("t6_rst_out_last", 32'(bus.out_last), 0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("t6_no_drain_after_rst", 32'(bus.out_valid), 0);

`ifdef UART_FRM_STATS_EN
        pl = {8'h77};
        send_frame(8'h60, pl, 8'h00, 1'b1);
        repeat (4) tick();
        check("stats_ok_cnt", 32'(ok_cnt), 32'(ok_seen));
        check("stats_err_cnt", 32'(err_cnt), 32'(err_seen));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
